cond_branch_unit: RTL and testbench

COND_BRANCH_UNIT -- requirements
Module: cond_branch_unit

---
 rtl/cond_branch_unit.sv | 180 ++++++++++++++++++
 tb/tb_cond_branch_unit.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cond_branch_unit.sv
// Conditional branch resolution unit.
// Holds a compare-flag register {E,G,L} with a valid bit, accepts one branch
// request at a time, resolves it against the flags and returns taken/pc_next
// through a valid/ready result handshake.
module cond_branch_unit #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    // Flag register write port
    input  logic             flag_we,
    input  logic             equal,
    input  logic             greater,
    input  logic             less,
    // Branch request
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] br_target,
    // Branch result
    output logic             res_valid,
    input  logic             res_ready,
    output logic             taken,
    output logic [WIDTH-1:0] pc_next,
    // Error reporting
    output logic             cond_err,
    output logic             flag_err
);

    // FSM encoding
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StEval = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StResp = 2'd3;

    // Condition codes
    localparam logic [2:0] CondAl  = 3'b000;
    localparam logic [2:0] CondEq  = 3'b001;
    localparam logic [2:0] CondNe  = 3'b010;
    localparam logic [2:0] CondGt  = 3'b011;
    localparam logic [2:0] CondLt  = 3'b100;
    localparam logic [2:0] CondGe  = 3'b101;
    localparam logic [2:0] CondLe  = 3'b110;
    localparam logic [2:0] CondRsv = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [2:0]       flags_q, flags_d;      // {E,G,L}
    logic             fv_q, fv_d;
    logic             flag_err_q, flag_err_d;
    logic [2:0]       cond_q, cond_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic             taken_q, taken_d;
    logic [WIDTH-1:0] pc_next_q, pc_next_d;

    logic [2:0]       flags_in;
    logic             flags_onehot;
    logic             accept;
    logic             no_flags_needed;
    logic             resolve;
    logic             cond_true;

    // Evaluate a condition code against the {E,G,L} flags.
    function automatic logic eval_cond(input logic [2:0] cond, input logic [2:0] flags);
        logic e, g, l;
        e = flags[2];
        g = flags[1];
        l = flags[0];
        unique case (cond)
            CondAl:  eval_cond = 1'b1;
            CondEq:  eval_cond = e;
            CondNe:  eval_cond = !e;
            CondGt:  eval_cond = g;
            CondLt:  eval_cond = l;
            CondGe:  eval_cond = g | e;
            CondLe:  eval_cond = l | e;
            default: eval_cond = 1'b0;
        endcase
    endfunction

    // Decode of handshake and resolution conditions.
    always_comb begin
        flags_in        = {equal, greater, less};
        flags_onehot    = (flags_in == 3'b100) || (flags_in == 3'b010) ||
                          (flags_in == 3'b001);
        accept          = (state_q == StIdle) && br_valid;
        // AL and the reserved code resolve without consulting the flags.
        no_flags_needed = (cond_q == CondAl) || (cond_q == CondRsv);
        resolve         = ((state_q == StEval) || (state_q == StWait)) &&
                          (no_flags_needed || fv_q);
        cond_true       = eval_cond(cond_q, flags_q);
    end

    // Next-state logic of the request FSM.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (br_valid) state_d = StEval;
            StEval: state_d = resolve ? StResp : StWait;
            StWait: if (resolve) state_d = StResp;
            StResp: if (res_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Flag register update; only one-hot writes are accepted, others flag an error.
    always_comb begin
        flags_d    = flags_q;
        fv_d       = fv_q;
        flag_err_d = flag_err_q;
        if (flag_we) begin
            if (flags_onehot) begin
                flags_d = flags_in;
                fv_d    = 1'b1;
            end else begin
                flag_err_d = 1'b1;
            end
        end
    end

    // Request fields are captured only on accept and held until the next one.
    always_comb begin
        cond_d   = cond_q;
        pc_d     = pc_q;
        target_d = target_q;
        if (accept) begin
            cond_d   = br_cond;
            pc_d     = pc;
            target_d = br_target;
        end
    end

    // Result registers load in the resolving cycle and hold otherwise.
    always_comb begin
        taken_d   = taken_q;
        pc_next_d = pc_next_q;
        if (resolve) begin
            taken_d   = cond_true;
            pc_next_d = cond_true ? target_q : (pc_q + WIDTH'(1));
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            flags_q    <= 3'b000;
            fv_q       <= 1'b0;
            flag_err_q <= 1'b0;
            cond_q     <= 3'b000;
            pc_q       <= '0;
            target_q   <= '0;
            taken_q    <= 1'b0;
            pc_next_q  <= '0;
        end else begin
            state_q    <= state_d;
            flags_q    <= flags_d;
            fv_q       <= fv_d;
            flag_err_q <= flag_err_d;
            cond_q     <= cond_d;
            pc_q       <= pc_d;
            target_q   <= target_d;
            taken_q    <= taken_d;
            pc_next_q  <= pc_next_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        br_ready  = (state_q == StIdle);
        res_valid = (state_q == StResp);
        taken     = taken_q;
        pc_next   = pc_next_q;
        // Pulses in the resolving cycle only; resolve is itself a single cycle.
        cond_err  = resolve && (cond_q == CondRsv);
        flag_err  = flag_err_q;
    end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Self-checking bench for cond_branch_unit: table vectors, directed corner
// sequences and a randomized run against a transaction-level reference model.
module tb_cond_branch_unit;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         flag_we, equal, greater, less;
    logic         br_valid, br_ready;
    logic [2:0]   br_cond;
    logic [W-1:0] pc, br_target;
    logic         res_valid, res_ready, taken;
    logic [W-1:0] pc_next;
    logic         cond_err, flag_err;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic [2:0]   fl;      // {E,G,L} written before the branch
        logic [2:0]   cond;
        logic [W-1:0] pc;
        logic [W-1:0] tgt;
        logic         exp_taken;
        logic [W-1:0] exp_pc;
    } vec_t;

    vec_t vecs[15];

    // Reference model state
    logic [2:0]   m_fl;
    logic         m_fv, m_ferr, m_busy, m_done, m_taken;
    logic [2:0]   m_cond;
    logic [W-1:0] m_pc, m_tgt, m_pcn;

    always #5 clk = ~clk;

    cond_branch_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_we   (flag_we),
        .equal     (equal),
        .greater   (greater),
        .less      (less),
        .br_valid  (br_valid),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .pc        (pc),
        .br_target (br_target),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .taken     (taken),
        .pc_next   (pc_next),
        .cond_err  (cond_err),
        .flag_err  (flag_err)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        flag_we   = 1'b0;
        equal     = 1'b0;
        greater   = 1'b0;
        less      = 1'b0;
        br_valid  = 1'b0;
        br_cond   = 3'b000;
        pc        = '0;
        br_target = '0;
        res_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " br_ready"},  {31'd0, br_ready},  32'd1);
        check({tag, " res_valid"}, {31'd0, res_valid}, 32'd0);
        check({tag, " taken"},     {31'd0, taken},     32'd0);
        check({tag, " pc_next"},   {16'd0, pc_next},   32'd0);
        check({tag, " cond_err"},  {31'd0, cond_err},  32'd0);
        check({tag, " flag_err"},  {31'd0, flag_err},  32'd0);
    endtask

    // Assert reset at a falling edge, check outputs, release at the next one.
    task automatic do_reset(input string tag);
        rst = 1'b0;
        clear_inputs();
        #1;
        check_reset_outputs(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_flags(input logic [2:0] fl);
        flag_we = 1'b1;
        {equal, greater, less} = fl;
        tick();
        flag_we = 1'b0;
        {equal, greater, less} = 3'b000;
    endtask

    // Returns at the falling edge of the cycle after the accept (N+1).
    task automatic send_br(input logic [2:0] cond, input logic [W-1:0] a, input logic [W-1:0] t);
        int guard;
        guard = 0;
        while (!br_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (!br_ready) check("br_ready wait", 32'd0, 32'd1);
        br_valid  = 1'b1;
        br_cond   = cond;
        pc        = a;
        br_target = t;
        tick();
        br_valid = 1'b0;
    endtask

    task automatic take_result();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    function automatic logic cond_holds(input logic [2:0] c, input logic [2:0] f);
        case (c)
            3'd0:    return 1'b1;
            3'd1:    return f[2];
            3'd2:    return !f[2];
            3'd3:    return f[1];
            3'd4:    return f[0];
            3'd5:    return f[1] || f[2];
            3'd6:    return f[0] || f[2];
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_fl = 3'b000; m_fv = 1'b0; m_ferr = 1'b0; m_busy = 1'b0; m_done = 1'b0;
        m_taken = 1'b0; m_pcn = '0; m_cond = 3'b000; m_pc = '0; m_tgt = '0;
    endtask

    initial begin
        logic resolving;
        logic t;
        logic [2:0] fw;

        vecs[0]  = '{3'b100, 3'b001, 16'h0010, 16'h0100, 1'b1, 16'h0100};
        vecs[1]  = '{3'b010, 3'b110, 16'hFFFF, 16'h0200, 1'b0, 16'h0000};
        vecs[2]  = '{3'b010, 3'b001, 16'h1234, 16'h5678, 1'b0, 16'h1235};
        vecs[3]  = '{3'b100, 3'b010, 16'h2000, 16'h3000, 1'b0, 16'h2001};
        vecs[4]  = '{3'b001, 3'b010, 16'h2000, 16'h3000, 1'b1, 16'h3000};
        vecs[5]  = '{3'b010, 3'b011, 16'h0040, 16'h0A00, 1'b1, 16'h0A00};
        vecs[6]  = '{3'b001, 3'b011, 16'h0040, 16'h0A00, 1'b0, 16'h0041};
        vecs[7]  = '{3'b001, 3'b100, 16'h7FFF, 16'h0001, 1'b1, 16'h0001};
        vecs[8]  = '{3'b100, 3'b100, 16'h7FFF, 16'h0001, 1'b0, 16'h8000};
        vecs[9]  = '{3'b100, 3'b101, 16'h0100, 16'h0ABC, 1'b1, 16'h0ABC};
        vecs[10] = '{3'b001, 3'b101, 16'h0100, 16'h0ABC, 1'b0, 16'h0101};
        vecs[11] = '{3'b100, 3'b110, 16'hFFFE, 16'h1111, 1'b1, 16'h1111};
        vecs[12] = '{3'b010, 3'b000, 16'h00FF, 16'hCAFE, 1'b1, 16'hCAFE};
        vecs[13] = '{3'b100, 3'b111, 16'hFFFF, 16'hBEEF, 1'b0, 16'h0000};
        vecs[14] = '{3'b001, 3'b110, 16'h0AAA, 16'h0BBB, 1'b1, 16'h0BBB};

        clear_inputs();
        #2;
        do_reset("reset");

        // Table vectors: flags written, then branch, result expected at N+2.
        for (int i = 0; i < 15; i++) begin
            do_flags(vecs[i].fl);
            send_br(vecs[i].cond, vecs[i].pc, vecs[i].tgt);
            check($sformatf("v%0d res_valid@N+1", i), {31'd0, res_valid}, 32'd0);
            check($sformatf("v%0d cond_err@N+1", i), {31'd0, cond_err},
                  {31'd0, vecs[i].cond == 3'b111});
            tick();
            check($sformatf("v%0d res_valid@N+2", i), {31'd0, res_valid}, 32'd1);
            check($sformatf("v%0d taken", i), {31'd0, taken}, {31'd0, vecs[i].exp_taken});
            check($sformatf("v%0d pc_next", i), {16'd0, pc_next}, {16'd0, vecs[i].exp_pc});
            take_result();
            check($sformatf("v%0d br_ready after", i), {31'd0, br_ready}, 32'd1);
        end

        // GT with no valid flags waits until G is written three cycles later.
        do_reset("reset gt");
        send_br(3'b011, 16'h0300, 16'h0777);
        check("wait N+1 res_valid", {31'd0, res_valid}, 32'd0);
        check("wait N+1 br_ready", {31'd0, br_ready}, 32'd0);
        tick();
        check("wait N+2 res_valid", {31'd0, res_valid}, 32'd0);
        tick();
        check("wait N+3 res_valid", {31'd0, res_valid}, 32'd0);
        flag_we = 1'b1; greater = 1'b1;
        tick();
        flag_we = 1'b0; greater = 1'b0;
        check("wait N+4 res_valid", {31'd0, res_valid}, 32'd0);
        check("wait N+4 br_ready", {31'd0, br_ready}, 32'd0);
        tick();
        check("wait N+5 res_valid", {31'd0, res_valid}, 32'd1);
        check("wait taken", {31'd0, taken}, 32'd1);
        check("wait pc_next", {16'd0, pc_next}, 32'h0777);
        take_result();

        // AL and reserved resolve without valid flags.
        do_reset("reset al");
        send_br(3'b000, 16'h0010, 16'h0ABC);
        check("al cond_err", {31'd0, cond_err}, 32'd0);
        tick();
        check("al res_valid@N+2", {31'd0, res_valid}, 32'd1);
        check("al taken", {31'd0, taken}, 32'd1);
        check("al pc_next", {16'd0, pc_next}, 32'h0ABC);
        take_result();
        send_br(3'b111, 16'h1234, 16'h4321);
        check("rsv cond_err pulse", {31'd0, cond_err}, 32'd1);
        tick();
        check("rsv cond_err clear", {31'd0, cond_err}, 32'd0);
        check("rsv res_valid", {31'd0, res_valid}, 32'd1);
        check("rsv taken", {31'd0, taken}, 32'd0);
        check("rsv pc_next", {16'd0, pc_next}, 32'h1235);
        take_result();

        // Illegal flag write is sticky and leaves flags alone; result held under backpressure.
        do_flags(3'b001);
        check("ferr after legal", {31'd0, flag_err}, 32'd0);
        do_flags(3'b110);
        check("ferr after E|G", {31'd0, flag_err}, 32'd1);
        send_br(3'b001, 16'h0500, 16'h0600);
        tick();
        for (int k = 0; k < 5; k++) begin
            br_valid = 1'b1; br_cond = 3'b000; pc = 16'h0999; br_target = 16'h0888;
            check($sformatf("hold%0d res_valid", k), {31'd0, res_valid}, 32'd1);
            check($sformatf("hold%0d taken", k), {31'd0, taken}, 32'd0);
            check($sformatf("hold%0d pc_next", k), {16'd0, pc_next}, 32'h0501);
            check($sformatf("hold%0d br_ready", k), {31'd0, br_ready}, 32'd0);
            tick();
        end
        br_valid = 1'b0;
        take_result();
        check("hold br_ready after", {31'd0, br_ready}, 32'd1);
        check("ferr still set", {31'd0, flag_err}, 32'd1);

        // Reset while waiting abandons the request.
        do_reset("reset pre-wait");
        send_br(3'b011, 16'h0042, 16'h0099);
        tick();
        do_reset("reset in wait");
        check("post-reset br_ready", {31'd0, br_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("post-reset res_valid %0d", k), {31'd0, res_valid}, 32'd0);
            tick();
        end

        // Randomized run against the reference model.
        do_reset("reset rand");
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rand reset");
                model_reset();
                continue;
            end
            // A pending request resolves once its condition needs no flags or flags are valid.
            resolving = m_busy && !m_done && (m_cond == 3'd0 || m_cond == 3'd7 || m_fv);
            check("rnd br_ready", {31'd0, br_ready}, {31'd0, !m_busy});
            check("rnd res_valid", {31'd0, res_valid}, {31'd0, m_done});
            check("rnd cond_err", {31'd0, cond_err}, {31'd0, resolving && m_cond == 3'd7});
            check("rnd flag_err", {31'd0, flag_err}, {31'd0, m_ferr});
            check("rnd taken", {31'd0, taken}, {31'd0, m_taken});
            check("rnd pc_next", {16'd0, pc_next}, {16'd0, m_pcn});

            br_valid  = $urandom_range(0, 1) == 1;
            br_cond   = 3'($urandom_range(0, 7));
            pc        = W'($urandom);
            br_target = W'($urandom);
            flag_we   = $urandom_range(0, 4) == 0;
            fw        = 3'($urandom_range(0, 7));
            {equal, greater, less} = fw;
            res_ready = $urandom_range(0, 1) == 1;
            @(posedge clk);

            if (resolving) begin
                t       = cond_holds(m_cond, m_fl);
                m_taken = t;
                m_pcn   = t ? m_tgt : m_pc + 16'd1;
                m_done  = 1'b1;
            end else if (m_done && res_ready) begin
                m_busy = 1'b0;
                m_done = 1'b0;
            end else if (!m_busy && br_valid) begin
                m_busy = 1'b1;
                m_cond = br_cond;
                m_pc   = pc;
                m_tgt  = br_target;
            end
            if (flag_we) begin
                if ($countones(fw) == 1) begin
                    m_fl = fw;
                    m_fv = 1'b1;
                end else begin
                    m_ferr = 1'b1;
                end
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
